// File: rtl/fcb_wb_slave.sv
// Wishbone classic responder for the FCB register window: four config words, W1C IRQ
// pending, IRQ enable, scratch and read-only fabric status, with programmable wait states.
module fcb_wb_slave #(
  parameter int WAIT_STATES = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   wb_address,
  input  logic [31:0]  wb_data_in,
  output logic [31:0]  wb_data_out,
  input  logic         wb_we,
  input  logic         wb_bus_cycle,
  input  logic [3:0]   wb_select,
  input  logic         wb_stb,
  output logic         wb_ack,
  output logic         wb_error,
  output logic [127:0] cfg_out,
  input  logic [31:0]  irq_set,
  input  logic [31:0]  status_in,
  output logic         irq
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    return (old_val & ~lane_mask(sel)) | (new_val & lane_mask(sel));
  endfunction

  function automatic logic access_err(input logic we, input logic [2:0] adr,
                                      input logic [3:0] sel);
    return (sel == 4'h0) || (we && (adr == 3'd7));
  endfunction

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [31:0] cfg_q [4];
  logic [31:0] cfg_d [4];
  logic [31:0] pend_q, pend_d;
  logic [31:0] en_q, en_d;
  logic [31:0] scratch_q, scratch_d;
  logic        ack_q, ack_d;
  logic        error_q, error_d;
  logic [31:0] dout_q, dout_d;

  logic        req_s;
  logic        commit_s;
  logic [2:0]  txn_addr_s;
  logic        txn_we_s;
  logic [3:0]  txn_sel_s;
  logic [31:0] txn_data_s;
  logic        txn_err_s;
  logic [31:0] pend_clr_s;
  logic [31:0] rdata_s;

  // Request FSM: latch the access in IDLE, count wait states, respond for one cycle.
  always_comb begin
    req_s    = wb_bus_cycle & wb_stb;
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    sel_d    = sel_q;
    data_d   = data_q;
    err_d    = err_q;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          addr_d = wb_address;
          we_d   = wb_we;
          sel_d  = wb_select;
          data_d = wb_data_in;
          err_d  = access_err(wb_we, wb_address, wb_select);
          if (WAIT_STATES == 0) begin
            state_d  = ST_RESP;
            commit_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!req_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d  = ST_RESP;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the commit happens straight from IDLE, before anything is latched.
  always_comb begin
    if (state_q == ST_IDLE) begin
      txn_addr_s = wb_address;
      txn_we_s   = wb_we;
      txn_sel_s  = wb_select;
      txn_data_s = wb_data_in;
      txn_err_s  = access_err(wb_we, wb_address, wb_select);
    end else begin
      txn_addr_s = addr_q;
      txn_we_s   = we_q;
      txn_sel_s  = sel_q;
      txn_data_s = data_q;
      txn_err_s  = err_q;
    end
  end

  // Register file updates; fabric IRQ events win over a same-cycle W1C.
  always_comb begin
    cfg_d      = cfg_q;
    en_d       = en_q;
    scratch_d  = scratch_q;
    pend_clr_s = 32'h0;
    if (commit_s && txn_we_s && !txn_err_s) begin
      case (txn_addr_s)
        3'd0, 3'd1, 3'd2, 3'd3:
          cfg_d[txn_addr_s[1:0]] = lane_merge(cfg_q[txn_addr_s[1:0]], txn_data_s, txn_sel_s);
        3'd4:    pend_clr_s = txn_data_s & lane_mask(txn_sel_s);
        3'd5:    en_d = lane_merge(en_q, txn_data_s, txn_sel_s);
        3'd6:    scratch_d = lane_merge(scratch_q, txn_data_s, txn_sel_s);
        default: pend_clr_s = 32'h0;
      endcase
    end else begin
      pend_clr_s = 32'h0;
    end
    pend_d = (pend_q & ~pend_clr_s) | irq_set;
  end

  // Read mux and response outputs; read data lives only for the response cycle.
  always_comb begin
    case (txn_addr_s)
      3'd0:    rdata_s = cfg_q[0];
      3'd1:    rdata_s = cfg_q[1];
      3'd2:    rdata_s = cfg_q[2];
      3'd3:    rdata_s = cfg_q[3];
      3'd4:    rdata_s = pend_q;
      3'd5:    rdata_s = en_q;
      3'd6:    rdata_s = scratch_q;
      3'd7:    rdata_s = status_in;
      default: rdata_s = 32'h0;
    endcase
    ack_d   = commit_s & ~txn_err_s;
    error_d = commit_s & txn_err_s;
    if (commit_s && !txn_we_s && !txn_err_s) begin
      dout_d = rdata_s;
    end else begin
      dout_d = 32'h0;
    end
  end

  // State and register flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 3'd0;
      we_q      <= 1'b0;
      sel_q     <= 4'h0;
      data_q    <= 32'h0;
      err_q     <= 1'b0;
      for (int i = 0; i < 4; i++) cfg_q[i] <= 32'h0;
      pend_q    <= 32'h0;
      en_q      <= 32'h0;
      scratch_q <= 32'h0;
      ack_q     <= 1'b0;
      error_q   <= 1'b0;
      dout_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      err_q     <= err_d;
      for (int i = 0; i < 4; i++) cfg_q[i] <= cfg_d[i];
      pend_q    <= pend_d;
      en_q      <= en_d;
      scratch_q <= scratch_d;
      ack_q     <= ack_d;
      error_q   <= error_d;
      dout_q    <= dout_d;
    end
  end

  assign wb_ack      = ack_q;
  assign wb_error    = error_q;
  assign wb_data_out = dout_q;
  assign cfg_out     = {cfg_q[3], cfg_q[2], cfg_q[1], cfg_q[0]};
  assign irq         = |(pend_q & en_q);

endmodule

// File: tb/tb_fcb_wb_slave.sv
// Bench for fcb_wb_slave: one instance with no wait states and one with three, checked
// every cycle against a register-level model plus hand-computed literal expectations.
module tb_fcb_wb_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         stb;
  logic [2:0]   adr  [2];
  logic [31:0]  wdat [2];
  logic         we   [2];
  logic         cyc  [2];
  logic [3:0]   sel  [2];
  logic [31:0]  irqs [2];
  logic [31:0]  stat [2];
  logic [31:0]  dout [2];
  logic         ack  [2];
  logic         err  [2];
  logic [127:0] cfg  [2];
  logic         irq  [2];

  fcb_wb_slave #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .wb_address(adr[0]), .wb_data_in(wdat[0]),
    .wb_data_out(dout[0]), .wb_we(we[0]), .wb_bus_cycle(cyc[0]), .wb_select(sel[0]),
    .wb_stb(stb), .wb_ack(ack[0]), .wb_error(err[0]), .cfg_out(cfg[0]),
    .irq_set(irqs[0]), .status_in(stat[0]), .irq(irq[0]));

  fcb_wb_slave #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .wb_address(adr[1]), .wb_data_in(wdat[1]),
    .wb_data_out(dout[1]), .wb_we(we[1]), .wb_bus_cycle(cyc[1]), .wb_select(sel[1]),
    .wb_stb(stb), .wb_ack(ack[1]), .wb_error(err[1]), .cfg_out(cfg[1]),
    .irq_set(irqs[1]), .status_in(stat[1]), .irq(irq[1]));

  // Model: the eight architectural words per instance and the expected response.
  logic [31:0] m_reg [2][8];
  logic        exp_ack  [2];
  logic        exp_err  [2];
  logic [31:0] exp_dout [2];
  logic        cm       [2];
  logic        cm_err   [2];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 8; r++) m_reg[d][r] = 32'h0;
      exp_ack[d] = 1'b0; exp_err[d] = 1'b0; exp_dout[d] = 32'h0;
      cm[d] = 1'b0; cm_err[d] = 1'b0;
    end
  endtask

  // One clock edge; the model applies any commit scheduled for this edge, then IRQ events.
  task automatic step();
    logic [31:0] m;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (cm[d] && !cm_err[d] && we[d]) begin
        m = mask_of(sel[d]);
        if (adr[d] == 3'd4) m_reg[d][4] = m_reg[d][4] & ~(wdat[d] & m);
        else m_reg[d][adr[d]] = (m_reg[d][adr[d]] & ~m) | (wdat[d] & m);
      end
      if (reset) m_reg[d][4] = m_reg[d][4] | irqs[d];
      cm[d] = 1'b0;
    end
    #1;
  endtask

  // One full Wishbone access; the master drops CYC after the response cycle begins.
  task automatic xfer(input int d, input logic [2:0] a, input logic w, input logic [3:0] s,
                      input logic [31:0] wd, input logic [31:0] iset, output logic [31:0] got);
    int ws;
    logic e;
    logic [31:0] rd;
    ws = (d == 0) ? 0 : 3;
    adr[d] = a; we[d] = w; sel[d] = s; wdat[d] = wd; cyc[d] = 1'b1;
    repeat (ws) step();
    e  = (s == 4'h0) || (w && (a == 3'd7));
    rd = (a == 3'd7) ? stat[d] : m_reg[d][a];
    cm[d] = 1'b1; cm_err[d] = e; irqs[d] = iset;
    step();
    irqs[d] = 32'h0;
    exp_ack[d] = !e; exp_err[d] = e; exp_dout[d] = (!e && !w) ? rd : 32'h0;
    got = dout[d];
    cyc[d] = 1'b0;
    step();
    exp_ack[d] = 1'b0; exp_err[d] = 1'b0; exp_dout[d] = 32'h0;
  endtask

  // Compare every output of both instances against the model once per cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("ack%0d", d), ack[d], exp_ack[d]);
      chk($sformatf("err%0d", d), err[d], exp_err[d]);
      chk($sformatf("cfg%0d", d), cfg[d],
          {m_reg[d][3], m_reg[d][2], m_reg[d][1], m_reg[d][0]});
      chk($sformatf("irq%0d", d), irq[d], |(m_reg[d][4] & m_reg[d][5]));
      if (!exp_err[d]) chk($sformatf("dout%0d", d), dout[d], exp_dout[d]);
    end
  end

  logic [31:0] got;

  initial begin
    reset = 1'b0; stb = 1'b1;
    for (int d = 0; d < 2; d++) begin
      adr[d] = 3'd0; wdat[d] = 32'h0; we[d] = 1'b0; cyc[d] = 1'b0;
      sel[d] = 4'h0; irqs[d] = 32'h0; stat[d] = 32'h0;
    end
    model_reset();
    repeat (2) step();
    chk("rst_cfg", cfg[0], 128'h0);
    chk("rst_ack", ack[1], 1'b0);
    reset = 1'b1;
    step();

    // Full word, then a single byte lane over an existing value.
    xfer(0, 3'd0, 1'b1, 4'hF, 32'hA5A5_1234, 32'h0, got);
    chk("w_reg0", cfg[0][31:0], 32'hA5A51234);
    xfer(0, 3'd1, 1'b1, 4'hF, 32'h1111_1111, 32'h0, got);
    xfer(0, 3'd1, 1'b1, 4'b0100, 32'h00CD_0000, 32'h0, got);
    chk("byte_reg1", cfg[0][63:32], 32'h11CD1111);
    xfer(0, 3'd1, 1'b0, 4'h1, 32'h0, 32'h0, got);
    chk("rd_reg1", got, 32'h11CD1111);

    // Error terminations leave every register untouched.
    xfer(0, 3'd7, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0, got);
    xfer(0, 3'd2, 1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0, got);
    xfer(0, 3'd2, 1'b0, 4'h0, 32'h0, 32'h0, got);
    chk("err_reg2", cfg[0][95:64], 32'h0);

    // IRQ pending: set, set-vs-W1C collision, then a clean clear.
    xfer(0, 3'd5, 1'b1, 4'hF, 32'h0000_0020, 32'h0, got);
    irqs[0] = 32'h0000_0020;
    step();
    irqs[0] = 32'h0;
    chk("irq_set", irq[0], 1'b1);
    xfer(0, 3'd4, 1'b1, 4'hF, 32'h0000_0020, 32'h0000_0020, got);
    chk("irq_collide", irq[0], 1'b1);
    xfer(0, 3'd4, 1'b1, 4'hF, 32'h0000_0020, 32'h0, got);
    chk("irq_clear", irq[0], 1'b0);

    xfer(0, 3'd6, 1'b1, 4'b1001, 32'hAABB_CCDD, 32'h0, got);
    xfer(0, 3'd6, 1'b0, 4'hF, 32'h0, 32'h0, got);
    chk("scratch", got, 32'hAA0000DD);

    // Three wait states: status read, write, abort during WAIT.
    stat[1] = 32'hDEAD_BEEF;
    xfer(1, 3'd7, 1'b0, 4'hF, 32'h0, 32'h0, got);
    chk("rd_status", got, 32'hDEADBEEF);
    chk("rd_status_gone", dout[1], 32'h0);
    xfer(1, 3'd0, 1'b1, 4'hF, 32'h1234_5678, 32'h0, got);
    adr[1] = 3'd0; we[1] = 1'b1; sel[1] = 4'hF; wdat[1] = 32'hFFFF_FFFF; cyc[1] = 1'b1;
    step(); step();
    cyc[1] = 1'b0;
    repeat (4) step();
    chk("abort_nowrite", cfg[1][31:0], 32'h12345678);

    // Reset while a transaction sits in WAIT.
    xfer(1, 3'd5, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0, got);
    irqs[1] = 32'h0000_0001;
    step();
    irqs[1] = 32'h0;
    chk("irq_pre_rst", irq[1], 1'b1);
    adr[1] = 3'd1; we[1] = 1'b1; sel[1] = 4'hF; wdat[1] = 32'h5555_5555; cyc[1] = 1'b1;
    step(); step();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_wait_ack", ack[1], 1'b0);
    chk("rst_wait_err", err[1], 1'b0);
    chk("rst_wait_cfg", cfg[1], 128'h0);
    chk("rst_wait_irq", irq[1], 1'b0);
    chk("rst_wait_dout", dout[1], 32'h0);
    cyc[1] = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    xfer(1, 3'd1, 1'b0, 4'hF, 32'h0, 32'h0, got);
    chk("post_rst_rd", got, 32'h0);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
